// File: rtl/expr_join_pipe.sv
// rtl/expr_join_pipe.sv - four-operand join feeding a 3-stage q = ((a-b)*(3c+1) - 4d) >>> 1 pipeline
//
// Purpose:
//   Each signed operand (a, b, c, d) arrives on its own valid/ready channel and is
//   parked in a one-entry holding register. When all four are present and stage 1
//   can accept, the set "fires" into a 3-stage datapath that computes
//   q = ((a - b) * (3c + 1) - 4d) >>> 1 at full precision. The result is then
//   narrowed to DATA_WIDTH, either by clamping (SATURATE=1) or by keeping the low
//   bits (SATURATE=0).
//
// Parameters:
//   DATA_WIDTH  signed width of every operand and of the result (>= 3)
//   SATURATE    1 = clamp to the signed range, 0 = two's-complement wrap
//
// Ports:
//   clk_i                 clock, rising edge
//   arst_i                asynchronous active-high reset
//   a_i .. d_i            signed operands
//   a_valid_i .. d_valid_i operand valids
//   a_ready_o .. d_ready_o operand readys
//   q_o                   narrowed signed result
//   q_sat_o               result did not fit and was clamped or wrapped
//   q_valid_o             result valid
//   q_ready_i             consumer ready

`timescale 1ns/1ps

module expr_join_pipe #(
    parameter int DATA_WIDTH = 5,
    parameter int SATURATE   = 1
) (
    input  logic                  clk_i,
    input  logic                  arst_i,

    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    input  logic [DATA_WIDTH-1:0] c_i,
    input  logic [DATA_WIDTH-1:0] d_i,

    input  logic                  a_valid_i,
    input  logic                  b_valid_i,
    input  logic                  c_valid_i,
    input  logic                  d_valid_i,

    output logic                  a_ready_o,
    output logic                  b_ready_o,
    output logic                  c_ready_o,
    output logic                  d_ready_o,

    output logic [DATA_WIDTH-1:0] q_o,
    output logic                  q_sat_o,
    output logic                  q_valid_o,
    input  logic                  q_ready_i
);

    localparam int W  = DATA_WIDTH;
    localparam int PW = 2 * W + 4;   // product width
    localparam int RW = 2 * W + 5;   // p - f needs one guard bit over the product

    localparam logic [W+2:0] ONE_T = {{(W+2){1'b0}}, 1'b1};
    localparam logic [W-1:0] Q_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] Q_MIN = {1'b1, {(W-1){1'b0}}};

    // ------------------------------------------------------------------
    // Operand holding registers
    // ------------------------------------------------------------------
    logic [W-1:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
    logic         a_full_q, a_full_d, b_full_q, b_full_d;
    logic         c_full_q, c_full_d, d_full_q, d_full_d;

    logic a_xfer, b_xfer, c_xfer, d_xfer;
    logic fire;

    // ------------------------------------------------------------------
    // Pipeline stage registers
    // ------------------------------------------------------------------
    logic         s1_valid_q, s1_valid_d;
    logic [W:0]   s1_diff_q, s1_diff_d;    // a - b
    logic [W+2:0] s1_t_q, s1_t_d;          // 3c + 1
    logic [W+1:0] s1_f_q, s1_f_d;          // d <<< 2

    logic         s2_valid_q, s2_valid_d;
    logic [PW-1:0] s2_p_q, s2_p_d;         // diff * t
    logic [W+1:0] s2_f_q, s2_f_d;

    logic         q_valid_q, q_valid_d;
    logic [W-1:0] q_q, q_d;
    logic         q_sat_q, q_sat_d;

    // Stage enables: a stage may load when it is empty or its successor moves.
    // This chain is purely combinational from q_ready_i back to the operand readys.
    logic s1_en, s2_en, s3_en;

    assign s3_en = ~q_valid_q | q_ready_i;
    assign s2_en = ~s2_valid_q | s3_en;
    assign s1_en = ~s1_valid_q | s2_en;

    assign fire = a_full_q & b_full_q & c_full_q & d_full_q & s1_en;

    // A full slot only opens in the cycle its contents leave with the fire.
    assign a_ready_o = ~a_full_q | fire;
    assign b_ready_o = ~b_full_q | fire;
    assign c_ready_o = ~c_full_q | fire;
    assign d_ready_o = ~d_full_q | fire;

    assign a_xfer = a_valid_i & a_ready_o;
    assign b_xfer = b_valid_i & b_ready_o;
    assign c_xfer = c_valid_i & c_ready_o;
    assign d_xfer = d_valid_i & d_ready_o;

    // A transfer in the fire cycle refills the slot, so it takes priority over
    // the clear that fire would otherwise cause.
    always_comb begin
        a_d      = a_q;
        a_full_d = a_full_q;
        if (a_xfer) begin
            a_d      = a_i;
            a_full_d = 1'b1;
        end else if (fire) begin
            a_full_d = 1'b0;
        end
    end

    always_comb begin
        b_d      = b_q;
        b_full_d = b_full_q;
        if (b_xfer) begin
            b_d      = b_i;
            b_full_d = 1'b1;
        end else if (fire) begin
            b_full_d = 1'b0;
        end
    end

    always_comb begin
        c_d      = c_q;
        c_full_d = c_full_q;
        if (c_xfer) begin
            c_d      = c_i;
            c_full_d = 1'b1;
        end else if (fire) begin
            c_full_d = 1'b0;
        end
    end

    always_comb begin
        d_d      = d_q;
        d_full_d = d_full_q;
        if (d_xfer) begin
            d_d      = d_i;
            d_full_d = 1'b1;
        end else if (fire) begin
            d_full_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: difference, 3c + 1 and 4d, all sign-extended explicitly
    // ------------------------------------------------------------------
    logic [W:0]   a_ext1, b_ext1;
    logic [W+2:0] c_ext3;

    assign a_ext1 = {a_q[W-1], a_q};
    assign b_ext1 = {b_q[W-1], b_q};
    assign c_ext3 = {{3{c_q[W-1]}}, c_q};

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_diff_d  = s1_diff_q;
        s1_t_d     = s1_t_q;
        s1_f_d     = s1_f_q;
        if (s1_en) begin
            s1_valid_d = fire;
            if (fire) begin
                s1_diff_d = a_ext1 - b_ext1;
                s1_t_d    = c_ext3 + (c_ext3 << 1) + ONE_T;
                s1_f_d    = {d_q, 2'b00};
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: full-width product. Both factors are sign-extended to the
    // product width, so the low PW bits of the unsigned product are the
    // correct two's-complement result.
    // ------------------------------------------------------------------
    logic [PW-1:0] diff_ext, t_ext;

    assign diff_ext = {{(W+3){s1_diff_q[W]}}, s1_diff_q};
    assign t_ext    = {{(W+1){s1_t_q[W+2]}}, s1_t_q};

    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_p_d     = s2_p_q;
        s2_f_d     = s2_f_q;
        if (s2_en) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_p_d = diff_ext * t_ext;
                s2_f_d = s1_f_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: subtract, floor-halve, narrow
    // ------------------------------------------------------------------
    logic [RW-1:0]        p_ext, f_ext;
    logic signed [RW-1:0] sum_s;
    logic signed [RW-1:0] r_s;
    logic [RW-W:0]        r_hi;
    logic                 r_fits;
    logic [W-1:0]         q_narrow;

    assign p_ext = {s2_p_q[PW-1], s2_p_q};
    assign f_ext = {{(W+3){s2_f_q[W+1]}}, s2_f_q};
    assign sum_s = p_ext - f_ext;
    assign r_s   = sum_s >>> 1;   // arithmetic shift == floor(x / 2)

    // r fits in W signed bits exactly when every bit from the W-bit sign
    // position upward is a copy of the sign.
    assign r_hi   = r_s[RW-1:W-1];
    assign r_fits = (&r_hi) | ~(|r_hi);

    always_comb begin
        q_narrow = r_s[W-1:0];
        if ((SATURATE != 0) && !r_fits) begin
            q_narrow = r_s[RW-1] ? Q_MIN : Q_MAX;
        end
    end

    always_comb begin
        q_valid_d = q_valid_q;
        q_d       = q_q;
        q_sat_d   = q_sat_q;
        if (s3_en) begin
            q_valid_d = s2_valid_q;
            if (s2_valid_q) begin
                q_d     = q_narrow;
                q_sat_d = ~r_fits;
            end
        end
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            a_q        <= '0;
            b_q        <= '0;
            c_q        <= '0;
            d_q        <= '0;
            a_full_q   <= 1'b0;
            b_full_q   <= 1'b0;
            c_full_q   <= 1'b0;
            d_full_q   <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_diff_q  <= '0;
            s1_t_q     <= '0;
            s1_f_q     <= '0;
            s2_valid_q <= 1'b0;
            s2_p_q     <= '0;
            s2_f_q     <= '0;
            q_valid_q  <= 1'b0;
            q_q        <= '0;
            q_sat_q    <= 1'b0;
        end else begin
            a_q        <= a_d;
            b_q        <= b_d;
            c_q        <= c_d;
            d_q        <= d_d;
            a_full_q   <= a_full_d;
            b_full_q   <= b_full_d;
            c_full_q   <= c_full_d;
            d_full_q   <= d_full_d;
            s1_valid_q <= s1_valid_d;
            s1_diff_q  <= s1_diff_d;
            s1_t_q     <= s1_t_d;
            s1_f_q     <= s1_f_d;
            s2_valid_q <= s2_valid_d;
            s2_p_q     <= s2_p_d;
            s2_f_q     <= s2_f_d;
            q_valid_q  <= q_valid_d;
            q_q        <= q_d;
            q_sat_q    <= q_sat_d;
        end
    end

    assign q_o       = q_q;
    assign q_sat_o   = q_sat_q;
    assign q_valid_o = q_valid_q;

endmodule

// File: tb/tb_expr_join_pipe.sv
// tb/tb_expr_join_pipe.sv - directed bench for expr_join_pipe, saturating and wrapping builds side by side

`timescale 1ns/1ps

module tb_expr_join_pipe;

    localparam int W = 5;

    logic         clk = 1'b0;
    logic         arst;
    logic [W-1:0] a, b, c, d;
    logic         av, bv, cv, dv;
    logic         q_ready;

    logic         ar, br, cr, dr;
    logic [W-1:0] q_s;
    logic         sat_s, qv_s;

    logic         ar_w, br_w, cr_w, dr_w;
    logic [W-1:0] q_w;
    logic         sat_w, qv_w;

    int n_checks = 0;
    int n_errors = 0;

    logic [2*W+1:0] q_log[$];   // {sat_s, q_s, sat_w, q_w}

    always #5 clk = ~clk;

    expr_join_pipe #(.DATA_WIDTH(W), .SATURATE(1)) u_dut_sat (
        .clk_i(clk), .arst_i(arst),
        .a_i(a), .b_i(b), .c_i(c), .d_i(d),
        .a_valid_i(av), .b_valid_i(bv), .c_valid_i(cv), .d_valid_i(dv),
        .a_ready_o(ar), .b_ready_o(br), .c_ready_o(cr), .d_ready_o(dr),
        .q_o(q_s), .q_sat_o(sat_s), .q_valid_o(qv_s), .q_ready_i(q_ready)
    );

    expr_join_pipe #(.DATA_WIDTH(W), .SATURATE(0)) u_dut_wrap (
        .clk_i(clk), .arst_i(arst),
        .a_i(a), .b_i(b), .c_i(c), .d_i(d),
        .a_valid_i(av), .b_valid_i(bv), .c_valid_i(cv), .d_valid_i(dv),
        .a_ready_o(ar_w), .b_ready_o(br_w), .c_ready_o(cr_w), .d_ready_o(dr_w),
        .q_o(q_w), .q_sat_o(sat_w), .q_valid_o(qv_w), .q_ready_i(q_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Accepted results, sampled on the falling edge before the handshake edge.
    always @(negedge clk) begin
        if (!arst && qv_s && q_ready) q_log.push_back({sat_s, q_s, sat_w, q_w});
    end

    // Present the masked channels (bit3=a .. bit0=d) and drop each valid after its transfer.
    task automatic send(input logic [3:0] m, input logic [W-1:0] va, vb, vc, vd);
        logic [3:0] pend;
        int k;
        a = va; b = vb; c = vc; d = vd;
        pend = m;
        {av, bv, cv, dv} = m;
        k = 0;
        while (pend != 4'd0 && k < 50) begin
            @(negedge clk);
            if (av && ar) pend[3] = 1'b0;
            if (bv && br) pend[2] = 1'b0;
            if (cv && cr) pend[1] = 1'b0;
            if (dv && dr) pend[0] = 1'b0;
            @(posedge clk); #1;
            {av, bv, cv, dv} = pend;
            k++;
        end
        if (pend != 4'd0) begin
            check("send_timeout", {28'd0, pend}, 32'd0);
            {av, bv, cv, dv} = 4'd0;
        end
    endtask

    task automatic wait_results(input int n);
        int k;
        k = 0;
        while (q_log.size() < n && k < 100) begin
            @(posedge clk);
            k++;
        end
        #1;
        check("result_count", q_log.size(), n);
    endtask

    task automatic check_result(input string tag, input logic [W-1:0] eq_s, input logic es_s,
                                input logic [W-1:0] eq_w, input logic es_w);
        logic [2*W+1:0] e;
        if (q_log.size() == 0) begin
            check({tag, "_missing"}, 32'd0, 32'd1);
        end else begin
            e = q_log.pop_front();
            check({tag, "_q_sat"},    {27'd0, e[2*W:W+1]}, {27'd0, eq_s});
            check({tag, "_flag_sat"}, {31'd0, e[2*W+1]},   {31'd0, es_s});
            check({tag, "_q_wrap"},   {27'd0, e[W-1:0]},   {27'd0, eq_w});
            check({tag, "_flag_wrap"},{31'd0, e[W]},       {31'd0, es_w});
        end
    endtask

    // Back-to-back stream, hand-computed results
    logic [W-1:0] ta [6] = '{5'h03, 5'h00, 5'h02, 5'h1d, 5'h05, 5'h18};
    logic [W-1:0] tb [6] = '{5'h01, 5'h01, 5'h00, 5'h02, 5'h1b, 5'h07};
    logic [W-1:0] tc [6] = '{5'h02, 5'h00, 5'h01, 5'h01, 5'h03, 5'h02};
    logic [W-1:0] td [6] = '{5'h01, 5'h00, 5'h00, 5'h1f, 5'h02, 5'h03};
    logic [W-1:0] eqs[6] = '{5'h05, 5'h1f, 5'h04, 5'h18, 5'h0f, 5'h10};
    logic         ess[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [W-1:0] eqw[6] = '{5'h05, 5'h1f, 5'h04, 5'h18, 5'h0e, 5'h05};

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        arst = 1'b1;
        a = '0; b = '0; c = '0; d = '0;
        {av, bv, cv, dv} = 4'd0;
        q_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_qv",     {31'd0, qv_s},  32'd0);
        check("rst_q",      {27'd0, q_s},   32'd0);
        check("rst_sat",    {31'd0, sat_s}, 32'd0);
        check("rst_qv_w",   {31'd0, qv_w},  32'd0);
        #2 arst = 1'b0;
        @(negedge clk);
        check("rst_ready",   {28'd0, ar, br, cr, dr},         32'hf);
        check("rst_ready_w", {28'd0, ar_w, br_w, cr_w, dr_w}, 32'hf);
        @(posedge clk); #1;

        // Single op and latency: captured on edge E0, result visible after E3
        send(4'hf, 5'd3, 5'd1, 5'd2, 5'd1);
        @(negedge clk); check("lat_e0", {31'd0, qv_s}, 32'd0);
        @(negedge clk); check("lat_e1", {31'd0, qv_s}, 32'd0);
        @(negedge clk); check("lat_e2", {31'd0, qv_s}, 32'd0);
        @(negedge clk); check("lat_e3", {31'd0, qv_s}, 32'd1);
        check("lat_e3_w", {31'd0, qv_w}, 32'd1);
        wait_results(1);
        check_result("single", 5'h05, 1'b0, 5'h05, 1'b0);

        // Negative floor
        send(4'hf, 5'd0, 5'd1, 5'd0, 5'd0);
        wait_results(1);
        check_result("neg_floor", 5'h1f, 1'b0, 5'h1f, 1'b0);

        // Overflow: r = 745
        send(4'hf, 5'h0f, 5'h10, 5'h0f, 5'h10);
        wait_results(1);
        check_result("overflow", 5'h0f, 1'b1, 5'h09, 1'b1);

        // Staggered arrival: a@0 (then a new a held valid), c@2, d@5, b@7
        for (int cyc = 0; cyc < 10; cyc++) begin
            av = (cyc <= 8);
            a  = (cyc == 0) ? 5'd2 : 5'd7;
            cv = (cyc == 2); c = 5'd1;
            dv = (cyc == 5); d = 5'd2;
            bv = (cyc == 7); b = 5'd1;
            @(negedge clk);
            if (cyc == 0)                check("stag_a_ready0", {31'd0, ar}, 32'd1);
            if (cyc >= 1 && cyc <= 7)    check("stag_a_blocked", {31'd0, ar}, 32'd0);
            if (cyc == 8)                check("stag_a_refill", {31'd0, ar}, 32'd1);
            @(posedge clk); #1;
        end
        {av, bv, cv, dv} = 4'd0;
        wait_results(1);
        check_result("staggered", 5'h1e, 1'b0, 5'h1e, 1'b0);

        // Reset mid-flight: the refilled a (7) is consumed by op1, op2 follows, a third a is held
        q_ready = 1'b0;
        send(4'b0111, 5'd0, 5'd1, 5'd0, 5'd0);
        send(4'hf, 5'd3, 5'd1, 5'd2, 5'd1);
        send(4'b1000, 5'd3, 5'd0, 5'd0, 5'd0);
        begin
            int k;
            k = 0;
            while (!qv_s && k < 40) begin
                @(negedge clk);
                k++;
            end
            check("mid_qv_before_rst", {31'd0, qv_s}, 32'd1);
        end
        #2 arst = 1'b1;
        #1;
        check("mid_qv_drop",   {31'd0, qv_s}, 32'd0);
        check("mid_qv_drop_w", {31'd0, qv_w}, 32'd0);
        check("mid_q_clear",   {27'd0, q_s},  32'd0);
        {av, bv, cv, dv} = 4'd0;
        @(posedge clk);
        @(negedge clk);
        #2 arst = 1'b0;
        q_ready = 1'b1;
        q_log.delete();
        repeat (10) @(posedge clk);
        #1;
        check("mid_no_stale", q_log.size(), 0);
        send(4'b0111, 5'd0, 5'd1, 5'd2, 5'd1);
        repeat (10) @(posedge clk);
        #1;
        check("mid_a_needed", q_log.size(), 0);
        send(4'b1000, 5'd3, 5'd0, 5'd0, 5'd0);
        wait_results(1);
        check_result("mid_resend", 5'h05, 1'b0, 5'h05, 1'b0);

        // Backpressure: 6 back-to-back sets, consumer stalled for 7 cycles
        fork
            begin
                for (int i = 0; i < 6; i++) send(4'hf, ta[i], tb[i], tc[i], td[i]);
            end
            begin
                q_ready = 1'b0;
                for (int cyc = 0; cyc < 7; cyc++) begin
                    @(negedge clk);
                    if (cyc >= 4) begin
                        check("bp_qv_held",  {31'd0, qv_s},  32'd1);
                        check("bp_q_stable", {27'd0, q_s},   {27'd0, eqs[0]});
                        check("bp_sat_stable", {31'd0, sat_s}, {31'd0, ess[0]});
                        check("bp_ready_drop", {28'd0, ar, br, cr, dr}, 32'd0);
                    end
                    @(posedge clk); #1;
                end
                q_ready = 1'b1;
            end
        join
        wait_results(6);
        for (int i = 0; i < 6; i++) check_result($sformatf("bp%0d", i), eqs[i], ess[i], eqw[i], ess[i]);
        repeat (5) @(posedge clk);
        #1;
        check("bp_no_dup", q_log.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
